// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register hazard scoreboard.
package reg_scoreboard_pkg;

    // Architectural register file geometry.
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    // Number of decrements (0..2) hitting one counter in a cycle.
    function automatic logic [1:0] dec_count(input logic wb_hit, input logic kill_hit);
        return {wb_hit & kill_hit, wb_hit ^ kill_hit};
    endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// One per-register pending-write counter: +1 per issue, -0..2 per cycle for
// write-back/kill, floors at zero and flags the cycle a decrement is lost.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [1:0]       dec2,
    output logic [CNT_W-1:0] count,
    output logic             nz,
    output logic             underflow
);

    localparam int SW = CNT_W + 1;
    localparam logic [SW-1:0] MAXV = SW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SW-1:0]    sum;

    // Net delta for this cycle; a short fall clamps to zero and reports underflow.
    always_comb begin
        sum       = SW'(count_q) + SW'(inc);
        underflow = 1'b0;
        count_d   = count_q;
        if (sum < SW'(dec2)) begin
            underflow = 1'b1;
            count_d   = '0;
        end else if ((sum - SW'(dec2)) > MAXV) begin
            count_d = MAXV[CNT_W-1:0];
        end else begin
            count_d = CNT_W'(sum - SW'(dec2));
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign nz    = |count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard beside Decode: counts outstanding writes per
// architectural register and stalls Decode on RAW hazards or a full counter.
// Handshake: an instruction is accepted (o_issue_fire) in the cycle where
// i_issue_valid is high, o_hazard is low and i_ex_stall is low; nothing else
// consumes it, so Decode holds its inputs until that cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_issue_valid,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_rs1_used,
    input  logic                 i_rs2_used,
    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic                 i_rd_wr,
    input  logic                 i_ex_stall,
    input  logic                 i_wb_valid,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic                 i_kill_valid,
    input  logic [REG_IDX_W-1:0] i_kill_rd,
    output logic                 o_hazard,
    output logic                 o_issue_fire,
    output logic [NREGS-1:0]     o_busy_vec,
    output logic [CNT_W+4:0]     o_inflight,
    output logic                 o_err
);

    localparam int INF_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [1:0]       dec [NREGS];
    logic [NREGS-1:0] nz;
    logic [NREGS-1:0] uf;
    logic [NREGS-1:0] inc;

    logic src_haz1, src_haz2, full_haz;
    logic byp1, byp2;

    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [INF_W-1:0] add_sum, sub_sum;
    logic [1:0]       applied;
    logic             err_q, err_d;

    // x0 is never tracked.
    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;
    assign uf[0]  = 1'b0;

    // Hazard decode from the current counters; bypass only when this
    // write-back retires the last pending write to the source.
    always_comb begin
        byp1     = WB_BYPASS && i_wb_valid && (i_wb_rd == i_rs1) && (cnt[i_rs1] == CNT_ONE);
        byp2     = WB_BYPASS && i_wb_valid && (i_wb_rd == i_rs2) && (cnt[i_rs2] == CNT_ONE);
        src_haz1 = i_rs1_used && (i_rs1 != '0) && nz[i_rs1] && !byp1;
        src_haz2 = i_rs2_used && (i_rs2 != '0) && nz[i_rs2] && !byp2;
        full_haz = i_rd_wr && (i_rd != '0) && (cnt[i_rd] == CNT_MAX);
        o_hazard     = i_issue_valid && (src_haz1 || src_haz2 || full_haz);
        o_issue_fire = i_issue_valid && !o_hazard && !i_ex_stall;
    end

    // Per-register increment / decrement requests for this cycle.
    always_comb begin
        inc = '0;
        for (int r = 0; r < NREGS; r++) begin
            dec[r] = 2'b00;
            if (r != 0) begin
                inc[r] = o_issue_fire && i_rd_wr && (i_rd == REG_IDX_W'(r));
                dec[r] = dec_count(i_wb_valid && (i_wb_rd == REG_IDX_W'(r)),
                                   i_kill_valid && (i_kill_rd == REG_IDX_W'(r)));
            end
        end
    end

    for (genvar g = 1; g < NREGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[g]),
            .dec2      (dec[g]),
            .count     (cnt[g]),
            .nz        (nz[g]),
            .underflow (uf[g])
        );
    end

    // Total in-flight: increments minus only the decrements that actually landed.
    always_comb begin
        add_sum = '0;
        sub_sum = '0;
        applied = 2'b00;
        for (int r = 1; r < NREGS; r++) begin
            applied = uf[r] ? {1'b0, inc[r] | nz[r]} : dec[r];
            add_sum = add_sum + INF_W'(inc[r]);
            sub_sum = sub_sum + INF_W'(applied);
        end
        inflight_d = inflight_q + add_sum - sub_sum;
        err_d      = err_q | (|uf);
    end

    // In-flight total and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign o_busy_vec = nz;
    assign o_inflight = inflight_q;
    assign o_err      = err_q;

endmodule
